// File: rtl/rand_arbiter_if.sv
// rand_arbiter_if
//   Bundle between the shared random-number server and its requesters.
//   req        requester -> server  per-requester level draw request
//   ack        server -> requester  one-hot, one-cycle delivery strobe
//   rnd_data   server -> requester  last delivered random value (held)
//   busy       server status        high while a draw is in flight
//   lfsr_state server debug view    current LFSR register
//   modport master: requester side; modport slave: server side.
interface rand_arbiter_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic [7:0]      rnd_data;
  logic            busy;
  logic [7:0]      lfsr_state;

  modport master (
    output req,
    input  ack,
    input  rnd_data,
    input  busy,
    input  lfsr_state
  );

  modport slave (
    input  req,
    output ack,
    output rnd_data,
    output busy,
    output lfsr_state
  );
endinterface

// File: rtl/rand_arbiter.sv
// rand_arbiter
//   Shared random-number server for the PONG game logic. One 8-bit
//   maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1) serves draws to NREQ
//   requesters through a round-robin req/ack handshake. After a grant the
//   LFSR advances STEPS more edges before the value is delivered; the LFSR
//   free-runs while idle and is held only on the delivery edge.
//   Parameters: NREQ (1..8) requesters, STEPS (1..255) post-grant steps,
//               SEED reset value of the LFSR (0 is replaced by 8'h01).
//   Ports: clk          clock
//          rst          synchronous active-high reset
//          bus (slave)  req in / ack, rnd_data, busy, lfsr_state out
module rand_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned STEPS = 8,
  parameter logic [7:0]  SEED  = 8'h01
) (
  input logic           clk,
  input logic           rst,
  rand_arbiter_if.slave bus
);

  localparam int unsigned   IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]    SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [7:0]    CNT_LOAD = 8'(STEPS);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DELIVER
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [7:0]      lfsr_q;
  logic [7:0]      lfsr_step;
  logic [7:0]      cnt_q;
  logic [NREQ-1:0] ack_q;
  logic [7:0]      rnd_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   gnt_q;

  logic [NREQ-1:0] eligible;
  logic            hit_hi;
  logic            hit_lo;
  logic [IW-1:0]   idx_hi;
  logic [IW-1:0]   idx_lo;
  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic            busy;

  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Round-robin selection. The requester acked this cycle is masked so a
  // held req produces separated draws. Search order (last+1)..NREQ-1 then
  // 0..last is split into two priority scans: the first eligible index
  // above last wins, otherwise the lowest eligible index overall (the wrap).
  always_comb begin
    eligible = bus.req & ~ack_q;
    hit_hi   = 1'b0;
    hit_lo   = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (eligible[i] && !hit_hi && (i > 32'(last_q))) begin
        hit_hi = 1'b1;
        idx_hi = IW'(i);
      end
      if (eligible[i] && !hit_lo) begin
        hit_lo = 1'b1;
        idx_lo = IW'(i);
      end
    end
    grant_found = hit_lo;
    grant_idx   = hit_hi ? idx_hi : idx_lo;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (cnt_q == 8'd1) begin
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath: LFSR, step counter, grant bookkeeping, delivery registers.
  // The LFSR is frozen only on the DELIVER edge, so the delivered value is
  // the register content seen during the DELIVER cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED_EFF;
      cnt_q  <= '0;
      ack_q  <= '0;
      rnd_q  <= '0;
      last_q <= LAST_RST;
      gnt_q  <= '0;
    end else begin
      ack_q <= '0;
      if (state_q != DELIVER) begin
        lfsr_q <= lfsr_step;
      end
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            gnt_q <= grant_idx;
            cnt_q <= CNT_LOAD;
          end
        end
        STEP: begin
          cnt_q <= cnt_q - 8'd1;
        end
        DELIVER: begin
          rnd_q        <= lfsr_q;
          ack_q[gnt_q] <= 1'b1;
          last_q       <= gnt_q;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rnd_data   = rnd_q;
  assign bus.busy       = busy;
  assign bus.lfsr_state = lfsr_q;

  // Structural invariants of the server.
  a_ack_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(ack_q));
  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (rst) lfsr_q != 8'h00);

endmodule

// File: tb/tb_rand_arbiter.sv
// tb_rand_arbiter
//   Scoreboard bench for rand_arbiter. Stimulus pushes the expected ack
//   (index, value, edge) into per-DUT queues; a monitor pops and compares
//   whenever a DUT raises ack. Three instances cover the parameter sets:
//   main (NREQ=3, STEPS=8, SEED=01), zero-seed free-run, and NREQ=1/STEPS=1.
module tb_rand_arbiter;

  typedef struct {
    logic [2:0]  ack;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  localparam logic [7:0] SEQ_A [10] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23,
                                         8'h47, 8'h8E, 8'h1C, 8'h38, 8'h38};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned base = 0;
  int unsigned n_checks = 0;
  int unsigned n_fails = 0;
  exp_t        q_a[$];
  exp_t        q_1[$];
  bit          seen [256];

  rand_arbiter_if #(.NREQ(3)) bus_a ();
  rand_arbiter_if #(.NREQ(3)) bus_z ();
  rand_arbiter_if #(.NREQ(1)) bus_1 ();

  rand_arbiter #(.NREQ(3), .STEPS(8), .SEED(8'h01)) u_main (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  rand_arbiter #(.NREQ(3), .STEPS(8), .SEED(8'h00)) u_seed0 (
    .clk (clk),
    .rst (rst),
    .bus (bus_z)
  );

  rand_arbiter #(.NREQ(1), .STEPS(1), .SEED(8'h01)) u_one (
    .clk (clk),
    .rst (rst),
    .bus (bus_1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int unsigned n);
    logic [7:0] q;
    q = s;
    for (int unsigned i = 0; i < n; i++) begin
      q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
    return q;
  endfunction

  function automatic exp_t mk(input logic [2:0] a, input logic [7:0] d, input int unsigned n);
    exp_t e;
    e.ack  = a;
    e.data = d;
    e.at   = base + n;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Call only at a negedge; returns at the negedge following edge n.
  task automatic at_edge(input int unsigned n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    bus_a.req = '0;
    bus_1.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_rst(input logic [2:0] ra, input logic r1);
    rst       = 1'b0;
    bus_a.req = ra;
    bus_1.req = r1;
    base      = cyc;
  endtask

  task automatic drained(input string name);
    n_checks++;
    if (q_a.size() != 0 || q_1.size() != 0) begin
      n_fails++;
      $display("FAIL %s_missing_ack: %0d expected acks outstanding, required 0",
               name, q_a.size() + q_1.size());
      q_a.delete();
      q_1.delete();
    end
  endtask

  // req[0] raised on release; one draw of 9 LFSR steps delivers 8'h38.
  task automatic first_draw();
    q_a.push_back(mk(3'b001, 8'h38, 10));
    for (int unsigned k = 1; k <= 10; k++) begin
      at_edge(k);
      chk("lfsr_seq", 32'(bus_a.lfsr_state), 32'(SEQ_A[k-1]));
      if (k < 10) chk("busy_in_draw", 32'(bus_a.busy), 32'd1);
    end
    bus_a.req = '0;
    at_edge(14);
    drained("first_draw");
  endtask

  // Monitor: every ack is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_a.ack != '0) begin
        chk("ack_a_onehot", 32'($onehot(bus_a.ack)), 32'd1);
        chk("busy_a_ack_cycle", 32'(bus_a.busy), 32'd0);
        if (q_a.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL ack_a_unexpected: ack=%b rnd_data=%h cycle %0d, required no ack",
                   bus_a.ack, bus_a.rnd_data, cyc);
        end else begin
          e = q_a.pop_front();
          chk("ack_a_index", 32'(bus_a.ack), 32'(e.ack));
          chk("ack_a_data", 32'(bus_a.rnd_data), 32'(e.data));
          chk("ack_a_cycle", cyc, e.at);
        end
      end
      if (bus_1.ack != '0) begin
        if (q_1.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL ack_1_unexpected: ack=%b rnd_data=%h cycle %0d, required no ack",
                   bus_1.ack, bus_1.rnd_data, cyc);
        end else begin
          e = q_1.pop_front();
          chk("ack_1_index", 32'({2'b00, bus_1.ack}), 32'(e.ack));
          chk("ack_1_data", 32'(bus_1.rnd_data), 32'(e.data));
          chk("ack_1_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  model;
    int unsigned nseen;

    bus_a.req = '0;
    bus_z.req = '0;
    bus_1.req = '0;

    // Reset values and first draw
    apply_reset();
    chk("reset_ack", 32'(bus_a.ack), 32'd0);
    chk("reset_rnd", 32'(bus_a.rnd_data), 32'd0);
    chk("reset_busy", 32'(bus_a.busy), 32'd0);
    chk("reset_lfsr", 32'(bus_a.lfsr_state), 32'h01);
    chk("reset_lfsr_seed0", 32'(bus_z.lfsr_state), 32'h01);
    release_rst(3'b001, 1'b0);
    first_draw();

    // Full contention: 0,1,2,0,1,2 every 10 cycles, 9 LFSR steps per draw
    apply_reset();
    release_rst(3'b111, 1'b0);
    for (int unsigned k = 0; k < 6; k++) begin
      q_a.push_back(mk(3'(3'b001 << (k % 3)), lfsr_adv(8'h01, 9 + 9 * k), 10 + 10 * k));
    end
    at_edge(60);
    bus_a.req = '0;
    at_edge(65);
    drained("contention");

    // req[1] alone (11-cycle spacing), then req[2] joins mid-draw
    apply_reset();
    release_rst(3'b010, 1'b0);
    q_a.push_back(mk(3'b010, lfsr_adv(8'h01, 9), 10));
    q_a.push_back(mk(3'b010, lfsr_adv(8'h01, 19), 21));
    q_a.push_back(mk(3'b100, lfsr_adv(8'h01, 28), 31));
    q_a.push_back(mk(3'b010, lfsr_adv(8'h01, 37), 41));
    at_edge(15);
    bus_a.req = 3'b110;
    at_edge(31);
    bus_a.req = 3'b010;
    at_edge(41);
    bus_a.req = '0;
    at_edge(46);
    drained("single_then_late");

    // Abort: grant at edge 47, reset on the edge after cnt reaches 4
    bus_a.req = 3'b001;
    at_edge(51);
    chk("abort_busy_before", 32'(bus_a.busy), 32'd1);
    rst = 1'b1;
    at_edge(52);
    chk("abort_ack", 32'(bus_a.ack), 32'd0);
    chk("abort_rnd", 32'(bus_a.rnd_data), 32'd0);
    chk("abort_busy", 32'(bus_a.busy), 32'd0);
    chk("abort_lfsr", 32'(bus_a.lfsr_state), 32'h01);
    release_rst(3'b001, 1'b0);
    first_draw();

    // SEED=0 instance: full period from 8'h01 back to 8'h01
    apply_reset();
    chk("seed0_start", 32'(bus_z.lfsr_state), 32'h01);
    release_rst(3'b000, 1'b0);
    for (int unsigned v = 0; v < 256; v++) seen[v] = 1'b0;
    seen[8'h01] = 1'b1;
    model = 8'h01;
    for (int unsigned n = 1; n <= 255; n++) begin
      at_edge(n);
      model = lfsr_adv(model, 1);
      chk("seed0_nonzero", 32'(bus_z.lfsr_state != 8'h00), 32'd1);
      chk("seed0_seq", 32'(bus_z.lfsr_state), 32'(model));
      if (n < 255) seen[bus_z.lfsr_state] = 1'b1;
    end
    chk("seed0_period", 32'(bus_z.lfsr_state), 32'h01);
    nseen = 0;
    for (int unsigned v = 0; v < 256; v++) begin
      if (seen[v]) nseen++;
    end
    chk("seed0_coverage", nseen, 32'd255);

    // NREQ=1, STEPS=1: one-cycle pulse, then a request withdrawn pre-grant
    apply_reset();
    release_rst(3'b000, 1'b1);
    q_1.push_back(mk(3'b001, 8'h04, 3));
    at_edge(1);
    bus_1.req = 1'b0;
    at_edge(4);
    bus_1.req = 1'b1;
    q_1.push_back(mk(3'b001, 8'h23, 7));
    at_edge(8);
    bus_1.req = 1'b0;
    at_edge(20);
    drained("steps1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rand_arbiter.md
# rand_arbiter

Shared random-number server for the PONG game logic. It owns one 8-bit maximal-length LFSR and serves draws to several requesters through a round-robin req/ack handshake. Typical requesters are serve direction, ball speed jitter and AI paddle error. For decorrelation, the LFSR advances a fixed number of steps between each grant and each delivery. The LFSR free-runs while idle, so player timing adds entropy.

## Interface
- NREQ, 3, number of requesters (1..8)
- STEPS, 8, LFSR steps taken per draw after grant (1..255)
- SEED, 8'h01, LFSR reset value; 0 is substituted by 8'h01
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester draw request, level
- ack  out  NREQ  one-hot, one-cycle pulse: rnd_data valid for that requester
- rnd_data  out  8  last delivered random value, held until next delivery
- busy  out  1  high whenever state != IDLE
- lfsr_state  out  8  current LFSR register (debug/verification)

## Operation
- LFSR is Fibonacci, polynomial x^8+x^6+x^5+x^4+1, period 255.
  - Update: q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}.
  - Never 0.
- LFSR steps on every clock edge except edges taken in DELIVER (held there).
- FSM states: IDLE, STEP, DELIVER.
  - IDLE, eligible req present: grant the first eligible index searching from (last+1) mod NREQ upward with wrap. Latch the grant index and load cnt=STEPS. Go to STEP.
  - IDLE, no eligible req: stay in IDLE.
  - STEP: decrement cnt each edge. On the edge where cnt==1, go to DELIVER.
  - DELIVER: register rnd_data<=lfsr_state and ack[g]<=1, set last<=g, go to IDLE.
- Eligible requester = req[i]==1 and ack[i]==0 in the current cycle. The requester just served is masked for one cycle, so a req held high yields repeated but separated draws.
- Requests arriving while busy wait; none are lost while req stays high. Dropping req before grant withdraws the request.
- last resets to NREQ-1, so requester 0 has first priority after reset.
- Reset values: state=IDLE, ack=0, rnd_data=0, busy=0, lfsr_state=SEED (or 8'h01), cnt=0, last=NREQ-1.
- Reset mid-operation: an in-flight draw is aborted and no ack is issued. All registers return to reset values on that edge.

## Timing
- Grant edge = the IDLE edge that sees an eligible req.
- ack rises STEPS+1 edges after the grant edge and lasts exactly one cycle.
- rnd_data updates on the same edge as ack.
- Delivered value = the LFSR advanced STEPS+1 steps from its value at the grant edge.
- Continuous contention: one ack every STEPS+2 cycles. The IDLE edge coinciding with an ack cycle is itself a grant edge for another requester.
- Single requester holding req: one ack every STEPS+3 cycles, due to the one masked IDLE cycle.
- busy is registered with state: high from the cycle after the grant edge through the ack cycle's preceding DELIVER cycle. busy is low in the ack cycle.

## Test plan
- Reset with SEED=8'h01, STEPS=8, then req[0]=1 from the first post-reset edge.
  - Required: ack[0] pulses after the 10th edge with rnd_data=8'h38.
  - Required: lfsr_state sequence 02,04,08,11,23,47,8E,1C,38, then held for one cycle.
- req=3'b111 held continuously.
  - Required: acks in order 0,1,2,0,1,2, spaced 10 cycles apart.
  - Required: ack always one-hot; each rnd_data matches the reference-model LFSR.
- Only req[1] held.
  - Required: acks every 11 cycles.
  - Required: req[2] raised mid-draw is granted next; after its ack, req[1] is served again.
- rst asserted during STEP (cnt=4).
  - Required: no ack ever issued for that draw.
  - Required: next cycle shows rnd_data=0, busy=0, lfsr_state=SEED.
  - Required: after release, a new draw behaves exactly as the first scenario.
- SEED=8'h00 with no requests for 255 cycles.
  - Required: lfsr_state starts at 8'h01 and returns to 8'h01 after 255 edges.
  - Required: lfsr_state never equals 0; all 255 nonzero values are visited.
- STEPS=1, NREQ=1, req[0] pulsed for one cycle.
  - Required: ack[0] after 2 edges.
  - Required: req dropped before the grant edge yields no ack.
